axi4_wr_feeder: RTL



---
 rtl/axi4_feeder_pkg.sv | 18 +
 rtl/fifo_v3.sv | 68 ++++++
 rtl/axi4_wr_feeder.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/axi4_feeder_pkg.sv
// Shared definitions for the AXI4 write feeder: FSM states, request/response
// bit positions and the words-per-beat helper.
package axi4_feeder_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } feeder_state_e;

    localparam int unsigned WR_IDX = 0;
    localparam int unsigned RD_IDX = 1;

    function automatic int unsigned words_per_beat(input int unsigned data_width,
                                                   input int unsigned word_bytes);
        return data_width / (8 * word_bytes);
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO with occupancy output, in the common_cells fifo_v3 port style.
// A push into a full FIFO is taken when a pop happens in the same cycle.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 8,
    localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH + 1)'(DEPTH);
    localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(DEPTH - 1);

    logic [ADDR_DEPTH-1:0] wr_ptr;
    logic [ADDR_DEPTH-1:0] rd_ptr;
    logic [ADDR_DEPTH:0]   status_cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    assign full_o  = (status_cnt == FULL_CNT);
    assign empty_o = (status_cnt == '0);
    assign usage_o = status_cnt[ADDR_DEPTH-1:0];
    assign data_o  = mem[rd_ptr];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            status_cnt <= '0;
        end else if (flush_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            status_cnt <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                status_cnt <= status_cnt + 1'b1;
            end else if (do_pop && !do_push) begin
                status_cnt <= status_cnt - 1'b1;
            end
        end
    end

    // Storage is left unreset; consumers qualify the head with empty_o.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

endmodule

// File: rtl/axi4_wr_feeder.sv
// Packs an input word stream into AXI beats, buffers them and hands bursts
// to axi4_mgr with an incrementing, wrapping write address.
module axi4_wr_feeder
    import axi4_feeder_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH   = 32,
    parameter int unsigned AXI_DATA_WIDTH   = 64,
    parameter int unsigned WORD_SIZE_BYTES  = 4,
    parameter int unsigned DATA_COUNT_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH       = 16,
    parameter int unsigned BURST_LEN        = 4,
    parameter int unsigned BASE_ADDR        = 'h5000,
    parameter int unsigned ADDR_SPAN        = 'h1000
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          word_valid_i,
    output logic                          word_ready_o,
    input  logic [8*WORD_SIZE_BYTES-1:0]  word_i,
    input  logic                          flush_i,
    output logic [1:0]                    req_o,
    input  logic [1:0]                    rsp_i,
    input  logic [1:0]                    wr_err_i,
    output logic [AXI_ADDR_WIDTH-1:0]     mgr_wr_addr_o,
    output logic [DATA_COUNT_WIDTH-1:0]   wr_data_count_o,
    output logic [AXI_DATA_WIDTH-1:0]     mgr_data_o,
    input  logic                          beat_pop_i,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int unsigned WPB        = words_per_beat(AXI_DATA_WIDTH, WORD_SIZE_BYTES);
    localparam int unsigned WORD_W     = 8 * WORD_SIZE_BYTES;
    localparam int unsigned LANE_W     = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int unsigned ADDR_DEPTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BEAT_BYTES = AXI_DATA_WIDTH / 8;
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_BASE  = AXI_ADDR_WIDTH'(BASE_ADDR);
    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = AXI_ADDR_WIDTH'(BASE_ADDR + ADDR_SPAN);
    localparam logic [LANE_W-1:0]         LAST_LANE  = LANE_W'(WPB - 1);

    feeder_state_e               state;
    logic                        ready_en;
    logic [AXI_DATA_WIDTH-1:0]   pack_q;
    logic [AXI_DATA_WIDTH-1:0]   beat_d;
    logic [LANE_W-1:0]           lane_q;
    logic                        flush_pend;
    logic [AXI_ADDR_WIDTH-1:0]   cur_addr;
    logic [AXI_ADDR_WIDTH-1:0]   addr_sum;
    logic [AXI_ADDR_WIDTH-1:0]   addr_next;
    logic [DATA_COUNT_WIDTH-1:0] pop_cnt;
    logic [DATA_COUNT_WIDTH-1:0] pop_cnt_nxt;
    logic [DATA_COUNT_WIDTH-1:0] burst_n;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [ADDR_DEPTH-1:0]       fifo_usage;
    logic [CNT_W-1:0]            fifo_cnt;
    logic [AXI_DATA_WIDTH-1:0]   fifo_head;
    logic                        accept;
    logic                        pad_now;
    logic                        push;
    logic                        pop;
    logic                        bad_pop;
    logic                        start;
    logic                        rsp_err;
    logic                        unused_rsp_rd;

    assign unused_rsp_rd = rsp_i[RD_IDX];

    assign word_ready_o = ready_en && !fifo_full;
    assign accept       = word_valid_i && word_ready_o;
    assign pad_now      = flush_pend && (lane_q != '0) && !fifo_full;
    assign push         = (accept && (lane_q == LAST_LANE)) || pad_now;
    assign pop          = beat_pop_i && (state == REQ) && !fifo_empty;
    assign bad_pop      = beat_pop_i && !pop;

    assign fifo_cnt = fifo_full ? CNT_W'(FIFO_DEPTH) : CNT_W'(fifo_usage);
    assign burst_n  = (fifo_cnt >= CNT_W'(BURST_LEN)) ? DATA_COUNT_WIDTH'(BURST_LEN)
                                                      : DATA_COUNT_WIDTH'(fifo_cnt);
    assign start    = (state == IDLE) &&
                      ((fifo_cnt >= CNT_W'(BURST_LEN)) ||
                       (flush_pend && (lane_q == '0) && (fifo_cnt != '0)));

    assign pop_cnt_nxt = pop_cnt + DATA_COUNT_WIDTH'(pop);
    assign rsp_err     = (state == REQ) && rsp_i[WR_IDX] &&
                         ((wr_err_i != 2'b00) || (pop_cnt_nxt != wr_data_count_o));
    assign addr_sum    = cur_addr + AXI_ADDR_WIDTH'(wr_data_count_o) * AXI_ADDR_WIDTH'(BEAT_BYTES);
    assign addr_next   = (addr_sum >= ADDR_LIMIT) ? ADDR_BASE : addr_sum;

    assign req_o[WR_IDX] = (state == REQ);
    assign req_o[RD_IDX] = 1'b0;
    assign mgr_data_o    = fifo_empty ? '0 : fifo_head;
    assign busy_o        = (lane_q != '0) || !fifo_empty || (state != IDLE);

    // A word arriving with a pad push is merged into the padded beat, so the
    // packer never needs two FIFO slots in one cycle.
    always_comb begin
        beat_d = pack_q;
        if (accept) begin
            beat_d[lane_q*WORD_W +: WORD_W] = word_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ready_en   <= 1'b0;
            pack_q     <= '0;
            lane_q     <= '0;
            flush_pend <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                pack_q <= '0;
                lane_q <= '0;
            end else if (accept) begin
                pack_q <= beat_d;
                lane_q <= lane_q + 1'b1;
            end
            if (flush_i) begin
                flush_pend <= 1'b1;
            end else if ((state == IDLE) && (lane_q == '0) && fifo_empty) begin
                flush_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state           <= IDLE;
            pop_cnt         <= '0;
            wr_data_count_o <= '0;
            mgr_wr_addr_o   <= ADDR_BASE;
            cur_addr        <= ADDR_BASE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state           <= REQ;
                        pop_cnt         <= '0;
                        wr_data_count_o <= burst_n;
                        mgr_wr_addr_o   <= cur_addr;
                    end
                end
                REQ: begin
                    pop_cnt <= pop_cnt_nxt;
                    if (rsp_i[WR_IDX]) begin
                        state    <= IDLE;
                        cur_addr <= addr_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            err_o <= 1'b0;
        end else if (bad_pop || rsp_err) begin
            err_o <= 1'b1;
        end
    end

    fifo_v3 #(
        .DATA_WIDTH (AXI_DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_beat_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rstn_i),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (beat_d),
        .push_i  (push),
        .data_o  (fifo_head),
        .pop_i   (pop)
    );

endmodule
